regfile_port_arbiter: RTL and testbench

- Shares the single 4x8 register file (one write port, two registered read ports) between NREQ requesters, for example a fetch/decode unit and a debug/monitor port.
- Selects one request per cycle using round-robin, drives the register-file port signals combinationally, and returns read data with a one-cycle registered response.
- Sits directly in front of the register file.

---
 rtl/regfile_arb_pkg.sv | 40 ++++
 rtl/rr_arbiter.sv | 36 +++
 rtl/regfile_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arb_pkg
// Shared constants and the rotate-and-find-first helper for the register-file
// port arbiter.
//   AW, DW     : default register address / data widths
//   NREQ_MAX   : largest supported requester count
//   PTR_W      : width of the round-robin pointer / winner index
//   rr_first_idx() : index of the first set request at or after ptr, wrapping
//                    modulo n (result is 0 when no request is set)
// -----------------------------------------------------------------------------
package regfile_arb_pkg;

    localparam int AW       = 2;
    localparam int DW       = 8;
    localparam int NREQ_MAX = 4;
    localparam int PTR_W    = 2;

    function automatic logic [PTR_W-1:0] rr_first_idx(
        input logic [NREQ_MAX-1:0] req,
        input logic [PTR_W-1:0]    ptr,
        input int                  n
    );
        logic [PTR_W-1:0] idx;
        logic             found;
        int               cand;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            // Both ptr and k are below n, so a single subtraction performs the wrap.
            cand = int'(ptr) + k;
            if (cand >= n) cand = cand - n;
            if (k < n && !found && req[cand[PTR_W-1:0]]) begin
                idx   = cand[PTR_W-1:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker.
//   req  [N-1:0]   : request vector
//   ptr            : index with the highest priority this cycle
//   en             : when low, no grant is issued
//   gnt  [N-1:0]   : one-hot grant (zero when en is low or nothing requests)
//   idx            : encoded winner index (meaningful only when any is high)
//   any            : a grant is issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [NREQ_MAX-1:0] req_ext;

    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        idx            = rr_first_idx(req_ext, ptr, N);
        any            = en & (|req);
        gnt            = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_port_arbiter
// Shares one 4x8 register file (one write port, two registered read ports)
// between NREQ requesters. One request is granted per cycle, round-robin; the
// winner drives the register-file port combinationally, and read data is
// returned one cycle after acceptance together with a one-hot rsp_valid.
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   stall                      : masks all grants for the cycle
//   req_valid/ready/write      : per-requester handshake and request kind
//   req_rs1/rs2/wreg/wdata     : per-requester fields, slice i = requester i
//   rsp_valid                  : one-hot, read data valid for requester i
//   rsp_data1/2                : read data (wired from the register file)
//   rf_*                       : register-file port
//
// Build option
//   REGFILE_ARB_WRITE_PRIO_EN  : when defined, any valid write hides all reads
//                                from the arbiter for that cycle (round-robin
//                                among the writes, shared pointer).
// -----------------------------------------------------------------------------
module regfile_port_arbiter
    import regfile_arb_pkg::PTR_W;
#(
    parameter int NREQ = 2,
    parameter int AW   = 2,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_rs1,
    input  logic [NREQ*AW-1:0] req_rs2,
    input  logic [NREQ*AW-1:0] req_wreg,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data1,
    output logic [DW-1:0]      rsp_data2,
    output logic [AW-1:0]      rf_read_reg1,
    output logic [AW-1:0]      rf_read_reg2,
    output logic               rf_reg_write,
    output logic [AW-1:0]      rf_write_reg,
    output logic [DW-1:0]      rf_write_data,
    input  logic [DW-1:0]      rf_read_data1,
    input  logic [DW-1:0]      rf_read_data2
);

    logic [PTR_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic             pend_q,    pend_d;
    logic [PTR_W-1:0] pend_id_q, pend_id_d;

    logic [NREQ-1:0]  arb_req;
    logic [NREQ-1:0]  gnt;
    logic [PTR_W-1:0] win_idx;
    logic             win_any;
    logic             win_write;

`ifdef REGFILE_ARB_WRITE_PRIO_EN
    logic [NREQ-1:0] wr_req;

    always_comb begin
        wr_req  = req_valid & req_write;
        arb_req = (|wr_req) ? wr_req : req_valid;
    end
`else
    always_comb begin
        arb_req = req_valid;
    end
`endif

    rr_arbiter #(.N(NREQ)) u_rr_arbiter (
        .req (arb_req),
        .ptr (rr_ptr_q),
        .en  (~stall),
        .gnt (gnt),
        .idx (win_idx),
        .any (win_any)
    );

    assign req_ready = gnt;

    // The grant is one-hot, so at most one slice is ever selected; a single
    // grant per cycle is also what keeps writes and reads from colliding.
    always_comb begin
        rf_reg_write  = 1'b0;
        rf_write_reg  = '0;
        rf_write_data = '0;
        rf_read_reg1  = '0;
        rf_read_reg2  = '0;
        win_write     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_write = req_write[i];
                if (req_write[i]) begin
                    rf_reg_write  = 1'b1;
                    rf_write_reg  = req_wreg[i*AW +: AW];
                    rf_write_data = req_wdata[i*DW +: DW];
                end else begin
                    rf_read_reg1  = req_rs1[i*AW +: AW];
                    rf_read_reg2  = req_rs2[i*AW +: AW];
                end
            end
        end
    end

    // Pointer moves past the winner on every accept; a read accept arms the
    // response for the next cycle, anything else clears it.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        pend_d    = win_any & ~win_write;
        pend_id_d = pend_id_q;
        if (win_any) begin
            rr_ptr_d = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
            if (!win_write) pend_id_d = win_idx;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            pend_q    <= 1'b0;
            pend_id_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            pend_q    <= pend_d;
            pend_id_q <= pend_id_d;
        end
    end

    // Decoded from flops only, so a reset drops the response immediately.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = pend_q && (int'(pend_id_q) == i);
        end
    end

    // The register file already registers its read data at the accept edge.
    assign rsp_data1 = rf_read_data1;
    assign rsp_data2 = rf_read_data2;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_port_arbiter
// Drives the arbiter with directed and random requester traffic, models the
// register file it sits in front of, and checks port drive and responses
// against a reference model built from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_regfile_port_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 2;
    localparam int DW   = 8;
    localparam int NREG = 1 << AW;

    logic               clk;
    logic               rst_n;
    logic               stall;
    logic [NREQ-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [NREQ*AW-1:0] req_rs1, req_rs2, req_wreg;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]      rsp_data1, rsp_data2;
    logic [AW-1:0]      rf_read_reg1, rf_read_reg2, rf_write_reg;
    logic               rf_reg_write;
    logic [DW-1:0]      rf_write_data, rf_read_data1, rf_read_data2;

    // Per-requester stimulus, packed onto the DUT buses below.
    logic          t_valid [NREQ];
    logic          t_write [NREQ];
    logic [AW-1:0] t_rs1   [NREQ];
    logic [AW-1:0] t_rs2   [NREQ];
    logic [AW-1:0] t_wreg  [NREQ];
    logic [DW-1:0] t_wdata [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_valid[g]             = t_valid[g];
        assign req_write[g]             = t_write[g];
        assign req_rs1[g*AW +: AW]      = t_rs1[g];
        assign req_rs2[g*AW +: AW]      = t_rs2[g];
        assign req_wreg[g*AW +: AW]     = t_wreg[g];
        assign req_wdata[g*DW +: DW]    = t_wdata[g];
    end

    regfile_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_wreg      (req_wreg),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_data1     (rsp_data1),
        .rsp_data2     (rsp_data2),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_reg2  (rf_read_reg2),
        .rf_reg_write  (rf_reg_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file environment: write port, registered read ports, read data
    // untouched on a write cycle.
    logic [DW-1:0] rf_mem [NREG];

    initial begin
        for (int r = 0; r < NREG; r++) rf_mem[r] = '0;
        rf_read_data1 = '0;
        rf_read_data2 = '0;
    end

    always @(posedge clk) begin
        if (rf_reg_write) begin
            rf_mem[rf_write_reg] <= rf_write_data;
        end else begin
            rf_read_data1 <= rf_mem[rf_read_reg1];
            rf_read_data2 <= rf_mem[rf_read_reg2];
        end
    end

    // ---------------------------------------------------------------- model
    typedef struct packed {
        logic [NREQ-1:0] ready;
        logic            we;
        logic [AW-1:0]   r1;
        logic [AW-1:0]   r2;
        logic [AW-1:0]   wr;
        logic [DW-1:0]   wd;
    } drive_t;

    int              m_ptr;
    logic [DW-1:0]   m_mem [NREG];
    logic [NREQ-1:0] exp_rsp_valid;
    logic [DW-1:0]   exp_d1, exp_d2;
    int              checks;
    int              failures;

    // Winner from the rules: scan upward from the pointer with wrap-around.
    function automatic int pick_winner();
        bit any_wr;
        any_wr = 1'b0;
        if (stall) return -1;
`ifdef REGFILE_ARB_WRITE_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (t_valid[i] && t_write[i]) any_wr = 1'b1;
`endif
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (t_valid[j] && (!any_wr || t_write[j])) return j;
        end
        return -1;
    endfunction

    function automatic drive_t expect_drive(input int w);
        drive_t d;
        d = '0;
        if (w >= 0) begin
            d.ready = NREQ'(1) << w;
            if (t_write[w]) begin
                d.we = 1'b1;
                d.wr = t_wreg[w];
                d.wd = t_wdata[w];
            end else begin
                d.r1 = t_rs1[w];
                d.r2 = t_rs2[w];
            end
        end
        return d;
    endfunction

    function automatic drive_t observed();
        return {req_ready, rf_reg_write, rf_read_reg1, rf_read_reg2, rf_write_reg, rf_write_data};
    endfunction

    // Advances one clock edge and updates the model; returns #1 after the edge.
    task automatic clock_edge(input int w);
        exp_rsp_valid = '0;
        if (w >= 0 && !t_write[w]) begin
            exp_rsp_valid = NREQ'(1) << w;
            exp_d1        = m_mem[t_rs1[w]];
            exp_d2        = m_mem[t_rs2[w]];
        end
        @(posedge clk);
        if (w >= 0) begin
            m_ptr = (w + 1) % NREQ;
            if (t_write[w]) m_mem[t_wreg[w]] = t_wdata[w];
        end
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit wr,
                           input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        t_valid[i] = v;
        t_write[i] = wr;
        t_rs1[i]   = a1;
        t_rs2[i]   = a2;
        t_wreg[i]  = wa;
        t_wdata[i] = wd;
    endtask

    task automatic model_reset();
        m_ptr         = 0;
        exp_rsp_valid = '0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        int w;
        drive_t e;
        rst_n = 1'b0;
        stall = 1'b0;
        set_req(0, 1, 0, 2'd0, 2'd0, 2'd0, 8'h00);
        set_req(1, 1, 0, 2'd0, 2'd0, 2'd0, 8'h00);
        for (int i = 0; i < NREG; i++) m_mem[i] = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== '0) begin
                failures++;
                $display("FAIL reset_rsp_valid cycle=%0d got=%b exp=%b", c, rsp_valid, {NREQ{1'b0}});
            end
            checks++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        w = pick_winner();
        e = expect_drive(w);
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL reset_first_grant got=%b exp=%b", req_ready, 2'b01);
        end
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL reset_drive got=%h exp=%h", observed(), e);
        end
        checks++;
        clock_edge(w);
        if (rsp_valid !== exp_rsp_valid || rsp_data1 !== exp_d1 || rsp_data2 !== exp_d2) begin
            failures++;
            $display("FAIL reset_first_rsp got=%b/%h/%h exp=%b/%h/%h",
                     rsp_valid, rsp_data1, rsp_data2, exp_rsp_valid, exp_d1, exp_d2);
        end
        checks++;
    endtask

    task automatic test_write_then_read();
        int w;
        drive_t e;
        @(negedge clk);
        set_req(0, 1, 1, 2'd0, 2'd0, 2'd2, 8'hA5);
        set_req(1, 0, 0, 2'd0, 2'd0, 2'd0, 8'h00);
        #1;
        w = pick_winner();
        e = expect_drive(w);
        if (observed() !== e) begin
            failures++;
            $display("FAIL wr_drive got=%h exp=%h", observed(), e);
        end
        checks++;
        clock_edge(w);
        if (rsp_valid !== exp_rsp_valid) begin
            failures++;
            $display("FAIL wr_no_rsp got=%b exp=%b", rsp_valid, exp_rsp_valid);
        end
        checks++;
        @(negedge clk);
        set_req(0, 0, 0, 2'd0, 2'd0, 2'd0, 8'h00);
        set_req(1, 1, 0, 2'd2, 2'd0, 2'd0, 8'h00);
        #1;
        w = pick_winner();
        e = expect_drive(w);
        if (observed() !== e) begin
            failures++;
            $display("FAIL raw_drive got=%h exp=%h", observed(), e);
        end
        checks++;
        clock_edge(w);
        if (rsp_valid !== 2'b10 || rsp_data1 !== 8'hA5 || rsp_data2 !== 8'h00) begin
            failures++;
            $display("FAIL raw_rsp got=%b/%h/%h exp=10/a5/00", rsp_valid, rsp_data1, rsp_data2);
        end
        checks++;
    endtask

    task automatic test_round_robin();
        int w;
        drive_t e;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            set_req(0, 1, 0, AW'($urandom), AW'($urandom), 2'd0, 8'h00);
            set_req(1, 1, 0, AW'($urandom), AW'($urandom), 2'd0, 8'h00);
            #1;
            w = pick_winner();
            e = expect_drive(w);
            if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10) || observed() !== e) begin
                failures++;
                $display("FAIL rr_grant cycle=%0d got=%h exp=%h", c, observed(), e);
            end
            checks++;
            clock_edge(w);
            if (rsp_valid !== exp_rsp_valid || rsp_data1 !== exp_d1 || rsp_data2 !== exp_d2) begin
                failures++;
                $display("FAIL rr_rsp cycle=%0d got=%b/%h/%h exp=%b/%h/%h", c,
                         rsp_valid, rsp_data1, rsp_data2, exp_rsp_valid, exp_d1, exp_d2);
            end
            checks++;
        end
    endtask

    task automatic test_stall();
        int w;
        int held;
        drive_t e;
        @(negedge clk);
        set_req(0, 1, 0, 2'd2, 2'd1, 2'd0, 8'h00);
        set_req(1, 1, 0, 2'd3, 2'd2, 2'd0, 8'h00);
        #1;
        w = pick_winner();
        e = expect_drive(w);
        if (observed() !== e) begin
            failures++;
            $display("FAIL stall_pre_drive got=%h exp=%h", observed(), e);
        end
        checks++;
        clock_edge(w);
        held = m_ptr;
        set_req(1, 1, 1, 2'd0, 2'd0, 2'd3, 8'h5A);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            stall = 1'b1;
            #1;
            // The response to the pre-stall read must show in the first stall cycle.
            if (c == 0 && (rsp_valid !== exp_rsp_valid || rsp_data1 !== exp_d1)) begin
                failures++;
                $display("FAIL stall_pending_rsp got=%b/%h exp=%b/%h",
                         rsp_valid, rsp_data1, exp_rsp_valid, exp_d1);
            end
            if (c == 0) checks++;
            if (req_ready !== '0 || rf_reg_write !== 1'b0) begin
                failures++;
                $display("FAIL stall_masked cycle=%0d got=%b/%b exp=00/0", c, req_ready, rf_reg_write);
            end
            checks++;
            w = pick_winner();
            clock_edge(w);
            if (rsp_valid !== exp_rsp_valid) begin
                failures++;
                $display("FAIL stall_rsp cycle=%0d got=%b exp=%b", c, rsp_valid, exp_rsp_valid);
            end
            checks++;
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        w = pick_winner();
        e = expect_drive(w);
        if (req_ready !== (NREQ'(1) << held) || observed() !== e) begin
            failures++;
            $display("FAIL stall_release_grant got=%h exp=%h held_ptr=%0d", observed(), e, held);
        end
        checks++;
        clock_edge(w);
    endtask

    task automatic test_mid_read_reset();
        int w;
        @(negedge clk);
        set_req(0, 1, 0, 2'd2, 2'd3, 2'd0, 8'h00);
        set_req(1, 0, 0, 2'd0, 2'd0, 2'd0, 8'h00);
        #1;
        w = pick_winner();
        clock_edge(w);
        if (rsp_valid !== 2'b01) begin
            failures++;
            $display("FAIL midrst_rsp_before got=%b exp=01", rsp_valid);
        end
        checks++;
        #1;
        rst_n = 1'b0;
        #1;
        if (rsp_valid !== '0) begin
            failures++;
            $display("FAIL midrst_async_clear got=%b exp=00", rsp_valid);
        end
        checks++;
        @(negedge clk);
        set_req(0, 0, 0, 2'd0, 2'd0, 2'd0, 8'h00);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_write_prio();
        int w;
        drive_t e;
        @(negedge clk);
        set_req(0, 1, 0, 2'd1, 2'd1, 2'd0, 8'h00);
        set_req(1, 1, 1, 2'd0, 2'd0, 2'd1, 8'h3C);
        #1;
        w = pick_winner();
        e = expect_drive(w);
`ifdef REGFILE_ARB_WRITE_PRIO_EN
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL prio_write_first got=%b exp=10", req_ready);
        end
        checks++;
`endif
        if (observed() !== e) begin
            failures++;
            $display("FAIL prio_drive0 got=%h exp=%h", observed(), e);
        end
        checks++;
        clock_edge(w);
        if (w >= 0) t_valid[w] = 1'b0;
        @(negedge clk);
        #1;
        w = pick_winner();
        e = expect_drive(w);
        if (observed() !== e) begin
            failures++;
            $display("FAIL prio_drive1 got=%h exp=%h", observed(), e);
        end
        checks++;
        clock_edge(w);
        if (rsp_valid !== exp_rsp_valid || (exp_rsp_valid != '0 && rsp_data1 !== exp_d1)) begin
            failures++;
            $display("FAIL prio_rsp got=%b/%h exp=%b/%h", rsp_valid, rsp_data1, exp_rsp_valid, exp_d1);
        end
        checks++;
`ifdef REGFILE_ARB_WRITE_PRIO_EN
        if (rsp_data1 !== 8'h3C) begin
            failures++;
            $display("FAIL prio_raw_data got=%h exp=3c", rsp_data1);
        end
        checks++;
`endif
    endtask

    task automatic test_random();
        int w;
        int last_w;
        drive_t e;
        last_w = -1;
        for (int i = 0; i < NREQ; i++) t_valid[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            stall = ($urandom_range(0, 7) == 0);
            // A requester changes its fields only once idle or just granted.
            for (int i = 0; i < NREQ; i++) begin
                if (!t_valid[i] || last_w == i) begin
                    set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                            AW'($urandom), AW'($urandom), AW'($urandom), DW'($urandom));
                end
            end
            #1;
            w = pick_winner();
            e = expect_drive(w);
            if (observed() !== e) begin
                failures++;
                $display("FAIL rand_drive cycle=%0d got=%h exp=%h", c, observed(), e);
            end
            checks++;
            clock_edge(w);
            last_w = w;
            if (rsp_valid !== exp_rsp_valid) begin
                failures++;
                $display("FAIL rand_rsp_valid cycle=%0d got=%b exp=%b", c, rsp_valid, exp_rsp_valid);
            end
            checks++;
            if (exp_rsp_valid != '0) begin
                if (rsp_data1 !== exp_d1 || rsp_data2 !== exp_d2) begin
                    failures++;
                    $display("FAIL rand_rsp_data cycle=%0d got=%h/%h exp=%h/%h",
                             c, rsp_data1, rsp_data2, exp_d1, exp_d2);
                end
                checks++;
            end
        end
        stall = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 2'd0, 2'd0, 2'd0, 8'h00);
        model_reset();
        test_reset();
        test_write_then_read();
        test_round_robin();
        test_stall();
        test_mid_read_reset();
        test_write_prio();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
